tpu_activation_loader: RTL
==========================

// Module: tpu_activation_loader
// PURPOSE
//  Producer side of the banked activation buffer's unified write port. Takes a packed beat stream
//  (valid/ready) from DMA/CPU and assembles ARRAY_SIZE-wide activation rows. Writes rows
//  sequentially into the shadow bank set. After the final row, waits for the consumer stream to
//  go idle, then pulses swap_banks so the loaded data becomes active for the systolic array.
// PARAMETERS
//  ARRAY_SIZE  8   activations per row (= buffer NUM_BANKS)
//  ACT_BITS    16  bits per activation
//  MAX_K       256 max rows per load
//  ADDR_WIDTH  16  unified write address width
//  BEAT_ACTS   4   activations per input beat; ARRAY_SIZE % BEAT_ACTS == 0; BPR = ARRAY_SIZE/BEAT_ACTS
// PORTS
//  clk              in   1                      clock
//  rst              in   1                      synchronous active-high reset
//  cfg_start        in   1                      start a load (accepted in IDLE only)
//  cfg_rows         in   $clog2(MAX_K)+1        rows to load, 1..MAX_K
//  cfg_base_addr    in   ADDR_WIDTH             address of row 0
//  in_valid         in   1                      beat valid
//  in_ready         out  1                      beat accepted when in_valid & in_ready
//  in_data          in   BEAT_ACTS*ACT_BITS     lane i = activation i of beat
//  in_last          in   1                      marks final beat of the load
//  consumer_busy    in   1                      buffer streaming in progress; blocks swap
//  unified_wr_en    out  1                      row write strobe
//  unified_wr_addr  out  ADDR_WIDTH             cfg_base_addr + row index (mod 2^ADDR_WIDTH)
//  unified_wr_data  out  ARRAY_SIZE*ACT_BITS    assembled row
//  swap_banks       out  1                      one-cycle swap pulse
//  busy             out  1                      state != IDLE
//  done             out  1                      one-cycle completion pulse
//  err              out  1                      sticky; cleared on accepted cfg_start
//  perf_rows        out  32                     rows written (feature-gated)
//  perf_stalls      out  32                     stall cycles (feature-gated)
// BEHAVIOUR
//  - Reset: state=IDLE, all counters 0, in_ready/unified_wr_en/swap_banks/busy/done/err=0, wr_addr/data=0.
//  - FSM: IDLE -> LOAD (on cfg_start, cfg_rows!=0); LOAD -> WAIT_SWAP (final row's write issued);
//    WAIT_SWAP -> DONE (cycle consumer_busy==0, swap_banks=1 that cycle); DONE -> IDLE (done=1 for 1 cycle).
//  - cfg_start with cfg_rows==0: err=1, IDLE -> DONE directly; no writes, no swap.
//  - cfg_start outside IDLE: ignored.
//  - in_ready = (state==LOAD). Beat k of a row (k=0..BPR-1) fills lanes k*BEAT_ACTS..+BEAT_ACTS-1.
//  - The handshake of beat BPR-1 produces unified_wr_en=1 on the next cycle for exactly one cycle,
//    with registered addr/data. No backpressure; sustained rate is 1 row per BPR cycles.
//  - Final row: the row whose index == cfg_rows-1.
//  - in_last on any beat other than final row's last beat: err=1, the beat is dropped, the partial
//    row is not written, FSM -> DONE, no swap.
//  - Final row's last beat without in_last: err=1, but the load completes normally with swap.
//  - Final write and WAIT_SWAP entry coincide; swap_banks never asserts in the same cycle as
//    unified_wr_en.
//  - rst mid-operation: return to IDLE next edge; rows already written are unspecified; no swap, no done.
// CONFIGURATION
//  TPU_LOADER_PERF_EN defined:
//   - perf_rows increments on every unified_wr_en.
//   - perf_stalls increments on each LOAD cycle with in_valid==0, and each WAIT_SWAP cycle with
//     consumer_busy==1.
//   - Both counters saturate at 2^32-1 and are cleared only by rst.
//  Undefined: perf_rows/perf_stalls tied to 0; no counter flops.
// TESTING
//  1. rows=3, base=0x10, BPR=2, 6 beats back-to-back, consumer idle -> writes at 0x10/0x11/0x12,
//     each 1 cycle after 2nd beat; swap_banks 1 cycle after last write; done next cycle.
//  2. Data check: beat0 lanes {1,2,3,4}, beat1 {5,6,7,8} -> unified_wr_data lanes 0..7 = 1..8.
//  3. consumer_busy held high 10 cycles after final write -> swap_banks asserts on first
//     consumer_busy==0 cycle; perf_stalls +10 (PERF_EN).
//  4. rows=4, in_last on beat 3 -> err=1, 1 write only, no swap, done pulses, busy drops.
//  5. cfg_rows=0 -> err=1, done pulse, no writes/swap; next cfg_start with rows=1 clears err.
//  6. rst asserted mid-row (after beat0) -> next cycle IDLE, in_ready=0, no write/swap/done.
//     A new load then starts at row 0.
//  7. rows=MAX_K=256, base=0xFFFF -> addresses wrap 0xFFFF, 0x0000, ... ; perf_rows=256 (PERF_EN).

Source files
------------

// File: rtl/tpu_activation_loader.sv
// ---------------------------------------------------------------------------
// tpu_activation_loader
//   Producer side of the activation buffer's unified write port. Packed beats
//   arriving over a valid/ready stream are assembled into ARRAY_SIZE-wide rows.
//   The rows are written one after another into the shadow bank set. After the
//   final row is written, the block waits for the consumer to go idle. It then
//   pulses swap_banks so that the freshly loaded bank set becomes active.
//
//   Optional feature: define TPU_LOADER_PERF_EN to build the saturating
//   perf_rows / perf_stalls counters. When the macro is undefined, both
//   outputs are tied to zero and no counter flops are built.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cfg_start         start a load (accepted in IDLE only)
//   cfg_rows          number of rows to load, 1..MAX_K (0 flags err)
//   cfg_base_addr     write address of row 0
//   in_valid/in_ready beat handshake; in_data lane i = activation i of beat
//   in_last           marks the final beat of the load
//   consumer_busy     buffer is streaming; holds off the bank swap
//   unified_wr_*      registered row write strobe / address / data
//   swap_banks        one-cycle bank swap pulse
//   busy, done, err   status (done is a one-cycle pulse, err is sticky)
//   perf_rows/stalls  performance counters (feature-gated)
// ---------------------------------------------------------------------------
module tpu_activation_loader #(
    parameter int ARRAY_SIZE = 8,
    parameter int ACT_BITS   = 16,
    parameter int MAX_K      = 256,
    parameter int ADDR_WIDTH = 16,
    parameter int BEAT_ACTS  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_start,
    input  logic [$clog2(MAX_K):0]         cfg_rows,
    input  logic [ADDR_WIDTH-1:0]          cfg_base_addr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BEAT_ACTS*ACT_BITS-1:0]  in_data,
    input  logic                           in_last,
    input  logic                           consumer_busy,
    output logic                           unified_wr_en,
    output logic [ADDR_WIDTH-1:0]          unified_wr_addr,
    output logic [ARRAY_SIZE*ACT_BITS-1:0] unified_wr_data,
    output logic                           swap_banks,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [31:0]                    perf_rows,
    output logic [31:0]                    perf_stalls
);

    localparam int BPR       = ARRAY_SIZE / BEAT_ACTS;
    localparam int BEAT_BITS = BEAT_ACTS * ACT_BITS;
    localparam int ROW_BITS  = ARRAY_SIZE * ACT_BITS;
    localparam int ROW_W     = $clog2(MAX_K) + 1;
    localparam int BEAT_W    = (BPR > 1) ? $clog2(BPR) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_SWAP,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [ROW_W-1:0]        r_rows;
    logic [ROW_W-1:0]        r_row;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [BEAT_W-1:0]       r_beat;
    logic [ROW_BITS-1:0]     r_acc;
    logic                    r_wr_en;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [ROW_BITS-1:0]     r_wr_data;
    logic                    r_err;

    logic                    w_hs;
    logic                    w_row_end;
    logic                    w_final_row;
    logic                    w_final_beat;
    logic                    w_swap;
    logic [ROW_BITS-1:0]     w_row_merged;

    assign w_hs         = in_valid && (r_state == S_LOAD);
    assign w_row_end    = (r_beat == BEAT_W'(BPR - 1));
    assign w_final_row  = (r_row == r_rows - 1'b1);
    assign w_final_beat = w_row_end && w_final_row;

    // The final write occurs in the first WAIT_SWAP cycle. Gating on r_wr_en
    // keeps the swap out of that cycle.
    assign w_swap = (r_state == S_WAIT_SWAP) && !consumer_busy && !r_wr_en;

    // The current beat is placed into its slot of the row being assembled.
    // The last beat's merged row is written directly, without waiting a cycle
    // for the accumulator to update.
    genvar gi;
    generate
        for (gi = 0; gi < BPR; gi++) begin : g_slot
            assign w_row_merged[gi*BEAT_BITS +: BEAT_BITS] =
                (r_beat == BEAT_W'(gi)) ? in_data : r_acc[gi*BEAT_BITS +: BEAT_BITS];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rows    <= '0;
            r_row     <= '0;
            r_base    <= '0;
            r_beat    <= '0;
            r_acc     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        if (cfg_rows == '0) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_rows  <= cfg_rows;
                            r_base  <= cfg_base_addr;
                            r_row   <= '0;
                            r_beat  <= '0;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        if (in_last && !w_final_beat) begin
                            // Early in_last: drop the beat and the partial row, then abort.
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_acc <= w_row_merged;
                            if (w_row_end) begin
                                r_beat    <= '0;
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_base + ADDR_WIDTH'(r_row);
                                r_wr_data <= w_row_merged;
                                r_row     <= r_row + 1'b1;
                                if (w_final_row) begin
                                    r_state <= S_WAIT_SWAP;
                                    // A missing in_last is flagged, but the load still completes.
                                    if (!in_last) begin
                                        r_err <= 1'b1;
                                    end
                                end
                            end else begin
                                r_beat <= r_beat + 1'b1;
                            end
                        end
                    end
                end
                S_WAIT_SWAP: begin
                    if (w_swap) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready        = (r_state == S_LOAD);
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);
    assign swap_banks      = w_swap;
    assign err             = r_err;
    assign unified_wr_en   = r_wr_en;
    assign unified_wr_addr = r_wr_addr;
    assign unified_wr_data = r_wr_data;

`ifdef TPU_LOADER_PERF_EN
    logic [31:0] r_perf_rows;
    logic [31:0] r_perf_stalls;
    logic        w_stall;

    assign w_stall = ((r_state == S_LOAD) && !in_valid) ||
                     ((r_state == S_WAIT_SWAP) && consumer_busy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_rows   <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (r_wr_en && (r_perf_rows != '1)) begin
                r_perf_rows <= r_perf_rows + 1'b1;
            end
            if (w_stall && (r_perf_stalls != '1)) begin
                r_perf_stalls <= r_perf_stalls + 1'b1;
            end
        end
    end

    assign perf_rows   = r_perf_rows;
    assign perf_stalls = r_perf_stalls;
`else
    assign perf_rows   = '0;
    assign perf_stalls = '0;
`endif

endmodule
